// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM state codes,
// ALUOp / ALUControl codes, datapath mux selects and the supported opcodes.
package cpu_pkg;

    localparam int STATE_W = 4;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Immediate format depends only on the opcode; unknown opcodes fall back to I.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps ALUOp, funct3, funct7b5 and op[5] onto the
// three-bit ALUControl code driven into the datapath ALU.
module alu_decoder
    import cpu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type with funct7b5 set subtracts; addi never does.
                    3'b000:  alu_control = ({op5, funct7b5} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Moore control FSM of the multicycle RISC-V CPU plus PCWrite logic.
// Optional performance counters are enabled with `define CPU_CONTROL_PERF_EN.
module cpu_control_fsm
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        Zero,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ImmSrc,
`ifdef CPU_CONTROL_PERF_EN
    output logic [31:0] CycleCount,
    output logic [31:0] InstrCount,
`endif
    output logic        RegWrite
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [1:0]         alu_op;
    logic               pc_update;
    logic               branch;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_FETCH;
        else      state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECUTER;
                    OP_I:         next_state = S_EXECUTEI;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  next_state = S_MEMWB;
            S_EXECUTER: next_state = S_ALUWB;
            S_EXECUTEI: next_state = S_ALUWB;
            S_JAL:      next_state = S_ALUWB;
            default:    next_state = S_FETCH;
        endcase
    end

    // NOTE: every output gets a default before the case, so states that do not
    // mention a signal drive 0 and no latch is inferred.
    always_comb begin
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_WD;
        alu_op    = ALUOP_ADD;
        RegWrite  = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                pc_update = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR, S_EXECUTEI: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                alu_op  = (state == S_EXECUTEI) ? ALUOP_FUNCT : ALUOP_ADD;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_A;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = SRCA_A;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite = pc_update | (branch & Zero);
    assign ImmSrc  = imm_src_of(op);

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

`ifdef CPU_CONTROL_PERF_EN
    logic retire;

    // Retirement is the last state of each legal instruction; illegal opcodes exit from DECODE.
    assign retire = (state == S_MEMWB) || (state == S_MEMWRITE) ||
                    (state == S_ALUWB) || (state == S_BEQ);

    always_ff @(posedge clk) begin
        if (!rst) begin
            CycleCount <= '0;
            InstrCount <= '0;
        end else begin
            CycleCount <= CycleCount + 32'd1;
            if (retire) InstrCount <= InstrCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: directed and random instructions
// compared cycle by cycle against a per-instruction control-word model.
module tb_cpu_control_fsm;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu_ctl;
        logic [1:0] imm_src;
        logic       reg_write;
    } ctrl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  op = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7b5 = 1'b0;
    logic        Zero = 1'b0;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
`ifdef CPU_CONTROL_PERF_EN
    logic [31:0] CycleCount, InstrCount;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc_m    = 0;
    int instr_m  = 0;
    ctrl_t obs;

    always #5 clk = ~clk;

    cpu_control_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
`ifdef CPU_CONTROL_PERF_EN
        .CycleCount (CycleCount),
        .InstrCount (InstrCount),
`endif
        .RegWrite   (RegWrite)
    );

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUControl, ImmSrc, RegWrite};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int instr_len(input logic [6:0] o);
        case (o)
            LW:               return 5;
            SW, RT, IT, JAL:  return 4;
            BEQ:              return 3;
            default:          return 2;
        endcase
    endfunction

    function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected control word for cycle c (0 = FETCH) of an instruction.
    function automatic ctrl_t ref_ctrl(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                       input logic z, input int c);
        ctrl_t e = '0;
        e.imm_src = (o == SW) ? 2'b01 : (o == BEQ) ? 2'b10 : (o == JAL) ? 2'b11 : 2'b00;
        if (c == 0) begin
            e.pc_write = 1'b1; e.ir_write = 1'b1; e.result_src = 2'b10; e.src_b = 2'b10;
        end else if (c == 1) begin
            e.src_a = 2'b01; e.src_b = 2'b01;
        end else begin
            case (o)
                LW, SW: begin
                    if (c == 2) begin e.src_a = 2'b10; e.src_b = 2'b01; end
                    else if (o == SW) begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
                    else if (c == 3) e.adr_src = 1'b1;
                    else begin e.result_src = 2'b01; e.reg_write = 1'b1; end
                end
                RT, IT: begin
                    if (c == 2) begin
                        e.src_a = 2'b10;
                        e.src_b = (o == IT) ? 2'b01 : 2'b00;
                        e.alu_ctl = ref_alu(f3, f7, o == RT);
                    end else e.reg_write = 1'b1;
                end
                BEQ: begin
                    e.src_a = 2'b10; e.alu_ctl = 3'b001; e.pc_write = z;
                end
                JAL: begin
                    if (c == 2) begin e.src_a = 2'b01; e.src_b = 2'b10; e.pc_write = 1'b1; end
                    else e.reg_write = 1'b1;
                end
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc_m = 0;
        instr_m = 0;
    endtask

    // zmode: -1 random Zero each cycle, 0/1 forced. abort_at: cycle in which reset hits (-1 none).
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zmode, input int abort_at);
        int n = instr_len(o);
        op = o; funct3 = f3; funct7b5 = f7;
        for (int c = 0; c < n; c++) begin
            Zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            @(negedge clk);
            check($sformatf("ctrl op=%b f3=%b f7=%b z=%b c=%0d", o, f3, f7, Zero, c),
                  32'(obs), 32'(ref_ctrl(o, f3, f7, Zero, c)));
`ifdef CPU_CONTROL_PERF_EN
            check("cycle_count", CycleCount, 32'(cyc_m));
            check("instr_count", InstrCount, 32'(instr_m));
`endif
            if (c == abort_at) begin
                rst = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b1;
                cyc_m = 0;
                instr_m = 0;
                return;
            end
            @(posedge clk);
            #1;
            cyc_m++;
        end
        if (n != 2) instr_m++;
    endtask

    initial begin
        logic [6:0] o;
        logic [6:0] legal [6];
        legal[0] = LW; legal[1] = SW; legal[2] = RT; legal[3] = IT; legal[4] = BEQ; legal[5] = JAL;

        do_reset();
        run_instr(LW,  3'b000, 1'b0, -1, -1);
        run_instr(SW,  3'b010, 1'b0, -1, -1);
        run_instr(BEQ, 3'b000, 1'b0,  1, -1);
        run_instr(RT,  3'b000, 1'b1, -1, -1);
        run_instr(RT,  3'b111, 1'b0, -1, -1);
        run_instr(RT,  3'b010, 1'b0, -1, -1);
        run_instr(RT,  3'b110, 1'b0, -1, -1);
        run_instr(IT,  3'b000, 1'b1, -1, -1);
        run_instr(BEQ, 3'b000, 1'b0,  0, -1);
        run_instr(JAL, 3'b000, 1'b0, -1, -1);
        run_instr(7'b1111111, 3'b000, 1'b0, 1, -1);
        run_instr(LW,  3'b000, 1'b0, -1, 3);
        run_instr(SW,  3'b000, 1'b0, -1, 3);
        run_instr(RT,  3'b000, 1'b1, -1, 3);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                do o = 7'($urandom);
                while (o inside {LW, SW, RT, IT, BEQ, JAL});
            end else begin
                o = legal[$urandom_range(0, 5)];
            end
            run_instr(o, 3'($urandom), 1'($urandom), -1,
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        @(negedge clk);
        check("final_fetch_irwrite", 32'(IRWrite), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
